// File: rtl/fetch_queue.sv
// Dual-issue fetch stage: owns the PC, drives the two-wide ROM, and buffers returned
// instruction pairs in an in-order queue whose two oldest entries are shown to decode.
module fetch_queue #(
  parameter int unsigned DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [9:0]  rom_addr,
  input  logic [31:0] rom_instr1,
  input  logic [31:0] rom_instr2,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [1:0]  out_valid,
  output logic [31:0] out_instr0,
  output logic [31:0] out_instr1,
  output logic [31:0] out_pc0,
  output logic [31:0] out_pc1,
  input  logic [1:0]  deq_cnt,
  output logic        fetch_fire
);

  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   pc;
  logic [31:0]   pc_next;
  logic [CW-1:0] count;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] head_p1;
  logic [PW-1:0] tail_p1;
  logic          inflight;
  logic          inflight_single;
  logic [31:0]   inflight_pc;
  logic          last_word;
  logic          fire;
  logic [1:0]    avail;
  logic [1:0]    enq_n;
  logic [1:0]    deq_n;

  logic [31:0] q_pc    [DEPTH];
  logic [31:0] q_instr [DEPTH];

  logic unused_redirect_bits;
  assign unused_redirect_bits = ^redirect_pc[1:0];

  always_comb begin
    head_p1   = head + PW'(1);
    tail_p1   = tail + PW'(1);
    rom_addr  = pc[11:2];
    last_word = (pc[11:2] == 10'h3FF);
    // The top ROM word has no partner, so that fetch wraps within the 12-bit window.
    pc_next   = last_word ? {pc[31:12], pc[11:0] + 12'd4} : pc + 32'd8;
    // Space is reserved for the pair still in flight; this cycle's dequeue is not credited.
    fire      = rst_n && !redirect_valid &&
                ((32'(count) + (inflight ? 32'd2 : 32'd0) + 32'd2) <= 32'(DEPTH));
    fetch_fire = fire;

    out_valid[0] = rst_n && (count != '0);
    out_valid[1] = rst_n && (count >= CW'(2));
    out_instr0   = out_valid[0] ? q_instr[head]    : NOP;
    out_pc0      = out_valid[0] ? q_pc[head]       : 32'd0;
    out_instr1   = out_valid[1] ? q_instr[head_p1] : NOP;
    out_pc1      = out_valid[1] ? q_pc[head_p1]    : 32'd0;

    avail = {1'b0, out_valid[0]} + {1'b0, out_valid[1]};
    deq_n = (deq_cnt > avail) ? avail : deq_cnt;
    enq_n = inflight ? (inflight_single ? 2'd1 : 2'd2) : 2'd0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc              <= {RESET_PC[31:2], 2'b00};
      count           <= '0;
      head            <= '0;
      tail            <= '0;
      inflight        <= 1'b0;
      inflight_single <= 1'b0;
      inflight_pc     <= 32'd0;
    end else if (redirect_valid) begin
      pc       <= {redirect_pc[31:2], 2'b00};
      count    <= '0;
      head     <= '0;
      tail     <= '0;
      inflight <= 1'b0;
    end else begin
      head     <= head + PW'(deq_n);
      tail     <= tail + PW'(enq_n);
      count    <= count + CW'(enq_n) - CW'(deq_n);
      inflight <= fire;
      if (fire) begin
        inflight_pc     <= pc;
        inflight_single <= last_word;
        pc              <= pc_next;
      end
    end
  end

  // Queue storage needs no reset; count/head/tail decide what is visible.
  always_ff @(posedge clk) begin
    if (rst_n && !redirect_valid && inflight) begin
      q_pc[tail]    <= inflight_pc;
      q_instr[tail] <= rom_instr1;
      if (!inflight_single) begin
        q_pc[tail_p1]    <= inflight_pc + 32'd4;
        q_instr[tail_p1] <= rom_instr2;
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a queue-based reference model plus a
// 1-cycle-latency ROM model, driven by directed scenarios and random traffic.
module tb_fetch_queue;

  localparam int unsigned DEPTH = 8;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic [9:0]  rom_addr;
  logic [31:0] rom_instr1;
  logic [31:0] rom_instr2;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [1:0]  out_valid;
  logic [31:0] out_instr0;
  logic [31:0] out_instr1;
  logic [31:0] out_pc0;
  logic [31:0] out_pc1;
  logic [1:0]  deq_cnt;
  logic        fetch_fire;

  int nchk = 0;
  int nerr = 0;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr),
    .rom_instr1(rom_instr1), .rom_instr2(rom_instr2),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_instr0(out_instr0), .out_instr1(out_instr1),
    .out_pc0(out_pc0), .out_pc1(out_pc1), .deq_cnt(deq_cnt), .fetch_fire(fetch_fire)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_fn(input logic [9:0] w);
    return {6'h2A, w, 6'h15, ~w};
  endfunction

  // ROM: data for the address seen at an edge appears during the following cycle.
  logic [9:0] rom_addr_q;
  always @(posedge clk) rom_addr_q <= rom_addr;
  assign rom_instr1 = rom_fn(rom_addr_q);
  assign rom_instr2 = rom_fn(rom_addr_q + 10'd1);

  // Reference model: a queue of {pc, instr} plus the PCs of the pair being fetched.
  typedef struct packed { logic [31:0] pc; logic [31:0] instr; } ent_t;
  ent_t        mq[$];
  logic [31:0] mpend[$];
  logic [31:0] mpc;
  bit          minfl;

  logic [1:0]  e_valid;
  logic [31:0] e_pc0, e_pc1, e_i0, e_i1;
  logic        e_fire;
  logic [9:0]  e_addr;

  function automatic bit m_fire();
    return rst_n && !redirect_valid && (mq.size() + (minfl ? 2 : 0) + 2 <= DEPTH);
  endfunction

  task automatic calc_exp();
    int n;
    n       = rst_n ? ((mq.size() >= 2) ? 2 : mq.size()) : 0;
    e_valid = (n == 2) ? 2'b11 : (n == 1) ? 2'b01 : 2'b00;
    e_pc0   = (n >= 1) ? mq[0].pc    : 32'd0;
    e_i0    = (n >= 1) ? mq[0].instr : 32'h13;
    e_pc1   = (n == 2) ? mq[1].pc    : 32'd0;
    e_i1    = (n == 2) ? mq[1].instr : 32'h13;
    e_fire  = m_fire();
    e_addr  = mpc[11:2];
  endtask

  task automatic model_edge();
    bit f;
    int avail, d;
    f = m_fire();
    if (!rst_n) begin
      mq.delete(); mpend.delete(); minfl = 0; mpc = RESET_PC & ~32'h3;
    end else if (redirect_valid) begin
      mq.delete(); mpend.delete(); minfl = 0; mpc = redirect_pc & ~32'h3;
    end else begin
      avail = (mq.size() >= 2) ? 2 : mq.size();
      d = (int'(deq_cnt) > avail) ? avail : int'(deq_cnt);
      repeat (d) void'(mq.pop_front());
      foreach (mpend[k]) mq.push_back({mpend[k], rom_fn(mpend[k][11:2])});
      mpend.delete();
      minfl = f;
      if (f) begin
        mpend.push_back(mpc);
        if (mpc[11:2] == 10'h3FF) begin
          mpc = (mpc & ~32'hFFF) | ((mpc + 32'd4) & 32'hFFF);
        end else begin
          mpend.push_back(mpc + 32'd4);
          mpc = mpc + 32'd8;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; redirect_valid = 1'b0; deq_cnt = 2'd0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0; deq_cnt = 2'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      nchk++;
      if (out_valid !== 2'b00 || rom_addr !== 10'd0 || fetch_fire !== 1'b0) begin
        nerr++;
        $display("[TB] FAIL reset_hold cyc%0d: valid=%b addr=%h fire=%b, want 00/000/0", i, out_valid, rom_addr, fetch_fire);
      end
    end
    tick();
    rst_n = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      calc_exp();
      nchk++;
      if ({out_valid, fetch_fire, rom_addr} !== {e_valid, e_fire, e_addr}) begin
        nerr++;
        $display("[TB] FAIL reset_release cyc%0d: valid=%b fire=%b addr=%h, want %b/%b/%h", c, out_valid, fetch_fire, rom_addr, e_valid, e_fire, e_addr);
      end
      if (c == 1) begin
        nchk++;
        if (fetch_fire !== 1'b1 || rom_addr !== 10'd0) begin
          nerr++;
          $display("[TB] FAIL first_fire: fire=%b addr=%h, want 1/000", fetch_fire, rom_addr);
        end
      end
      if (c == 3) begin
        nchk++;
        if (out_valid !== 2'b11 || out_pc0 !== 32'h0 || out_pc1 !== 32'h4) begin
          nerr++;
          $display("[TB] FAIL first_visible: valid=%b pc0=%h pc1=%h, want 11/0/4", out_valid, out_pc0, out_pc1);
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    deq_cnt = 2'd0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      calc_exp();
      nchk++;
      if (out_valid !== e_valid || fetch_fire !== e_fire || out_pc0 !== e_pc0) begin
        nerr++;
        $display("[TB] FAIL bp_fill cyc%0d: valid=%b fire=%b pc0=%h, want %b/%b/%h", c, out_valid, fetch_fire, out_pc0, e_valid, e_fire, e_pc0);
      end
      if (c >= 6) begin
        nchk++;
        if (out_valid !== 2'b11 || fetch_fire !== 1'b0) begin
          nerr++;
          $display("[TB] FAIL bp_full cyc%0d: valid=%b fire=%b, want 11/0", c, out_valid, fetch_fire);
        end
      end
      tick();
    end
    deq_cnt = 2'd1;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      nchk++;
      if (out_pc0 !== 32'(j * 4) || out_instr0 !== rom_fn(10'(j)) || out_valid[0] !== 1'b1) begin
        nerr++;
        $display("[TB] FAIL bp_drain %0d: pc0=%h i0=%h, want %h/%h", j, out_pc0, out_instr0, 32'(j * 4), rom_fn(10'(j)));
      end
      tick();
    end
  endtask

  task automatic test_streaming();
    logic [31:0] prev;
    do_reset();
    deq_cnt = 2'd2;
    prev = 32'd0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      calc_exp();
      nchk++;
      if (out_valid !== e_valid || fetch_fire !== e_fire || out_pc0 !== e_pc0 || out_pc1 !== e_pc1) begin
        nerr++;
        $display("[TB] FAIL stream_model cyc%0d: valid=%b fire=%b pc0=%h pc1=%h, want %b/%b/%h/%h", c, out_valid, fetch_fire, out_pc0, out_pc1, e_valid, e_fire, e_pc0, e_pc1);
      end
      if (c >= 3) begin
        nchk++;
        if (out_valid !== 2'b11 || fetch_fire !== 1'b1 || (c >= 4 && out_pc0 !== prev + 32'd8)) begin
          nerr++;
          $display("[TB] FAIL stream_rate cyc%0d: valid=%b fire=%b pc0=%h prev=%h, want 11/1/prev+8", c, out_valid, fetch_fire, out_pc0, prev);
        end
        prev = out_pc0;
      end
      tick();
    end
  endtask

  task automatic test_redirect();
    do_reset();
    deq_cnt = 2'd2;
    repeat (5) tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0043;
    @(negedge clk);
    nchk++;
    if (fetch_fire !== 1'b0) begin
      nerr++;
      $display("[TB] FAIL redir_nofire: fire=%b, want 0", fetch_fire);
    end
    tick();
    redirect_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      calc_exp();
      nchk++;
      if (c < 3 && out_valid !== 2'b00) begin
        nerr++;
        $display("[TB] FAIL redir_empty cyc%0d: valid=%b, want 00", c, out_valid);
      end
      if (c == 3 && (out_valid !== 2'b11 || out_pc0 !== 32'h40 || out_pc1 !== 32'h44 || out_instr0 !== rom_fn(10'h10))) begin
        nerr++;
        $display("[TB] FAIL redir_target: valid=%b pc0=%h pc1=%h i0=%h, want 11/40/44/%h", out_valid, out_pc0, out_pc1, out_instr0, rom_fn(10'h10));
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    do_reset();
    deq_cnt = 2'd0;
    repeat (2) tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0FFC;
    tick();
    redirect_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      if (c == 4) deq_cnt = 2'd1;
      if (c == 5) deq_cnt = 2'd0;
      @(negedge clk);
      calc_exp();
      nchk++;
      if (out_valid !== e_valid || out_pc0 !== e_pc0 || out_pc1 !== e_pc1 || out_instr0 !== e_i0 || out_instr1 !== e_i1 || rom_addr !== e_addr) begin
        nerr++;
        $display("[TB] FAIL wrap_model cyc%0d: valid=%b pc0=%h pc1=%h addr=%h, want %b/%h/%h/%h", c, out_valid, out_pc0, out_pc1, rom_addr, e_valid, e_pc0, e_pc1, e_addr);
      end
      if (c == 1 && (fetch_fire !== 1'b1 || rom_addr !== 10'h3FF)) begin
        nerr++;
        $display("[TB] FAIL wrap_fire1: fire=%b addr=%h, want 1/3ff", fetch_fire, rom_addr);
      end
      if (c == 3 && (out_valid !== 2'b01 || out_pc0 !== 32'hFFC || out_instr0 !== rom_fn(10'h3FF))) begin
        nerr++;
        $display("[TB] FAIL wrap_single: valid=%b pc0=%h i0=%h, want 01/ffc/%h", out_valid, out_pc0, out_instr0, rom_fn(10'h3FF));
      end
      if (c == 4 && (out_valid !== 2'b11 || out_pc1 !== 32'h0 || out_instr1 !== rom_fn(10'h0))) begin
        nerr++;
        $display("[TB] FAIL wrap_next: valid=%b pc1=%h i1=%h, want 11/0/%h", out_valid, out_pc1, out_instr1, rom_fn(10'h0));
      end
      if (c == 5 && (out_pc0 !== 32'h0 || out_pc1 !== 32'h4 || out_instr1 !== rom_fn(10'h1))) begin
        nerr++;
        $display("[TB] FAIL wrap_after: pc0=%h pc1=%h i1=%h, want 0/4/%h", out_pc0, out_pc1, out_instr1, rom_fn(10'h1));
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    deq_cnt = 2'd0;
    repeat (4) tick();
    rst_n = 1'b0;
    @(negedge clk);
    nchk++;
    if (out_valid !== 2'b00 || fetch_fire !== 1'b0) begin
      nerr++;
      $display("[TB] FAIL rstmid_hold: valid=%b fire=%b, want 00/0", out_valid, fetch_fire);
    end
    tick();
    rst_n = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      nchk++;
      if (c == 1 && (out_valid !== 2'b00 || fetch_fire !== 1'b1 || rom_addr !== 10'd0)) begin
        nerr++;
        $display("[TB] FAIL rstmid_restart: valid=%b fire=%b addr=%h, want 00/1/000", out_valid, fetch_fire, rom_addr);
      end
      if (c == 2 && out_valid !== 2'b00) begin
        nerr++;
        $display("[TB] FAIL rstmid_drop: valid=%b, want 00", out_valid);
      end
      if (c == 3 && (out_valid !== 2'b11 || out_pc0 !== 32'h0 || out_pc1 !== 32'h4)) begin
        nerr++;
        $display("[TB] FAIL rstmid_fresh: valid=%b pc0=%h pc1=%h, want 11/0/4", out_valid, out_pc0, out_pc1);
      end
      tick();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      deq_cnt = 2'($urandom_range(0, 3));
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc = ($urandom_range(0, 1) == 0) ? $urandom : (32'h0000_0FF0 | 32'($urandom_range(0, 15)));
      rst_n = ($urandom_range(0, 49) != 0);
      @(negedge clk);
      calc_exp();
      nchk++;
      if (out_valid !== e_valid || out_pc0 !== e_pc0 || out_pc1 !== e_pc1 || out_instr0 !== e_i0 ||
          out_instr1 !== e_i1 || fetch_fire !== e_fire || rom_addr !== e_addr) begin
        nerr++;
        $display("[TB] FAIL rand cyc%0d: got v=%b pc0=%h pc1=%h i0=%h i1=%h f=%b a=%h want v=%b pc0=%h pc1=%h i0=%h i1=%h f=%b a=%h",
                 c, out_valid, out_pc0, out_pc1, out_instr0, out_instr1, fetch_fire, rom_addr,
                 e_valid, e_pc0, e_pc1, e_i0, e_i1, e_fire, e_addr);
      end
      tick();
    end
    rst_n = 1'b1;
    redirect_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'd0;
    deq_cnt = 2'd0;
    test_reset();
    test_backpressure();
    test_streaming();
    test_redirect();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end

endmodule
